// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES-128 types, S-box and Rcon tables, and the GF(2^8)
//                helpers used by the iterative encryption core.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

   typedef logic [7:0]  byte_t;
   typedef logic [31:0] word_t;

   // Control states of the iterative core
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } aes_state_t;

   localparam logic [3:0] c_LAST_ROUND = 4'd10;

   // Forward S-box, entry 0 in the most significant byte
   localparam logic [2047:0] c_SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // S-box lookup
   function automatic byte_t sbox(input byte_t b);
      return c_SBOX[2047 - 8*int'(b) -: 8];
   endfunction

   // Round constant for key-expansion round r (1..10)
   function automatic byte_t rcon(input logic [3:0] r);
      byte_t v;
      case (r)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   // Multiply by x in GF(2^8) modulo 0x11b
   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // MixColumns on one column; row 0 in the most significant byte
   function automatic word_t mix_column(input word_t col);
      byte_t a0, a1, a2, a3;
      byte_t b0, b1, b2, b3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      return {b0, b1, b2, b3};
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox
//  Description : Combinational 8-bit AES forward S-box lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);

   assign o_byte = sbox(i_byte);

endmodule
`default_nettype wire

// File: rtl/aes128_encrypt.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_encrypt
//  Description : Iterative AES-128 encryption core, one round per clock, with
//                a start/finish handshake. Optional build macro
//                AES128_ENCRYPT_OUT_MASK_EN forces the ciphertext output to
//                zero whenever finish is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes128_encrypt
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] in,
   input  logic [127:0] key,
   output logic         finish,
   output logic [127:0] AES128_encrypt
);

   aes_state_t   r_fsm;
   logic [127:0] r_data;
   logic [127:0] r_rkey;
   logic [3:0]   r_round;
   logic         r_finish;

   logic [127:0] w_sub;
   logic [127:0] w_shift;
   logic [127:0] w_mix;
   word_t        w_rot;
   word_t        w_subword;
   word_t        w_temp;
   word_t        w_nk0, w_nk1, w_nk2, w_nk3;
   logic [127:0] w_next_key;
   logic [127:0] w_next_data;

   // SubBytes: one S-box per state byte
   for (genvar i = 0; i < 16; i++) begin : g_sub
      aes_sbox u_sbox (
         .i_byte (r_data[127-8*i -: 8]),
         .o_byte (w_sub[127-8*i -: 8])
      );
   end

   // ShiftRows: byte (row r, col c) takes byte (row r, col c+r mod 4)
   for (genvar i = 0; i < 16; i++) begin : g_shift
      localparam int c_ROW = i % 4;
      localparam int c_COL = i / 4;
      localparam int c_SRC = 4*((c_COL + c_ROW) % 4) + c_ROW;
      assign w_shift[127-8*i -: 8] = w_sub[127-8*c_SRC -: 8];
   end

   // MixColumns on each of the four columns
   for (genvar c = 0; c < 4; c++) begin : g_mix
      assign w_mix[127-32*c -: 32] = mix_column(w_shift[127-32*c -: 32]);
   end

   // Key expansion: RotWord of the last word, then SubWord through 4 S-boxes
   assign w_rot = {r_rkey[23:0], r_rkey[31:24]};

   for (genvar j = 0; j < 4; j++) begin : g_subword
      aes_sbox u_sbox (
         .i_byte (w_rot[31-8*j -: 8]),
         .o_byte (w_subword[31-8*j -: 8])
      );
   end

   assign w_temp     = w_subword ^ {rcon(r_round), 24'h000000};
   assign w_nk0      = r_rkey[127:96] ^ w_temp;
   assign w_nk1      = r_rkey[95:64]  ^ w_nk0;
   assign w_nk2      = r_rkey[63:32]  ^ w_nk1;
   assign w_nk3      = r_rkey[31:0]   ^ w_nk2;
   assign w_next_key = {w_nk0, w_nk1, w_nk2, w_nk3};

   // The final round skips MixColumns
   assign w_next_data = ((r_round == c_LAST_ROUND) ? w_shift : w_mix) ^ w_next_key;

   // Control FSM plus state, round-key, counter and finish registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsm    <= ST_IDLE;
         r_data   <= '0;
         r_rkey   <= '0;
         r_round  <= 4'd0;
         r_finish <= 1'b0;
      end else begin
         case (r_fsm)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_data   <= in ^ key;
                  r_rkey   <= key;
                  r_round  <= 4'd1;
                  r_finish <= 1'b0;
                  r_fsm    <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               r_data <= w_next_data;
               r_rkey <= w_next_key;
               if (r_round == c_LAST_ROUND) begin
                  r_finish <= 1'b1;
                  r_fsm    <= ST_DONE;
               end else begin
                  r_round <= r_round + 4'd1;
               end
            end
            default: begin
               r_fsm <= ST_IDLE;
            end
         endcase
      end
   end

   assign finish = r_finish;

`ifdef AES128_ENCRYPT_OUT_MASK_EN
   assign AES128_encrypt = r_finish ? r_data : 128'd0;
`else
   assign AES128_encrypt = r_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes128_encrypt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes128_encrypt
//  Description : Scoreboard bench for aes128_encrypt with a byte-array AES
//                reference model whose S-box is derived from GF(2^8) inverses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes128_encrypt;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] pt;
   logic [127:0] key;
   logic         finish;
   logic [127:0] ct;

   aes128_encrypt dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .in             (pt),
      .key            (key),
      .finish         (finish),
      .AES128_encrypt (ct)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [127:0] ct;
      int           due;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;
   int   rises  = 0;

   logic [7:0] sb_ref [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d;
      d = {v, v};
      return d[15-n -: 8];
   endfunction

   // S-box from multiplicative inverse followed by the affine map
   function automatic void build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endfunction

   function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [31:0]  w [44];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] r;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sb_ref[tmp[31:24]], sb_ref[tmp[23:16]], sb_ref[tmp[15:8]], sb_ref[tmp[7:0]]};
            tmp = tmp ^ {rc, 24'h0};
            rc  = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int rd = 1; rd <= 10; rd++) begin
         for (int i = 0; i < 16; i++) t[i] = sb_ref[s[i]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
               s[4*c+row] = t[4*((c+row)%4)+row];
         if (rd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Monitor: pop and compare on each finish rise, check DONE stability
   logic         prev_f  = 1'b0;
   logic [127:0] prev_ct = '0;
   always @(negedge clk) begin
      if (!rst) begin
         if (finish && !prev_f) begin
            rises = rises + 1;
            if (sbq.size() == 0) begin
               checks = checks + 1;
               errors = errors + 1;
               $display("FAIL unexpected_finish: finish rose at cycle %0d with nothing expected, out=%h", cyc, ct);
            end else begin
               mon_e  = sbq.pop_front();
               checks = checks + 2;
               if (ct !== mon_e.ct) begin
                  errors = errors + 1;
                  $display("FAIL ciphertext: got %h expected %h", ct, mon_e.ct);
               end
               if (cyc != mon_e.due) begin
                  errors = errors + 1;
                  $display("FAIL latency: finish at cycle %0d expected cycle %0d", cyc, mon_e.due);
               end
            end
         end else if (finish && prev_f) begin
            checks = checks + 1;
            if (ct !== prev_ct) begin
               errors = errors + 1;
               $display("FAIL done_stable: out changed to %h from %h", ct, prev_ct);
            end
         end
      end
      prev_f  = finish;
      prev_ct = ct;
   end

   task automatic check1(input string name, input logic [127:0] got, input logic [127:0] req);
      checks = checks + 1;
      if (got !== req) begin
         errors = errors + 1;
         $display("FAIL %s: got %h expected %h", name, got, req);
      end
   endtask

   // Issue a request, holding start for 'hold' edges
   task automatic start_op(input logic [127:0] k, input logic [127:0] p,
                           input logic [127:0] exp, input int hold);
      @(negedge clk);
      key   = k;
      pt    = p;
      start = 1'b1;
      sbq.push_back('{exp, cyc + 11});
      @(negedge clk);
      check1("finish_drop", {127'd0, finish}, 128'd0);
      repeat (hold - 1) @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_finish(input string tag);
      int n;
      n = 0;
      while (!finish && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!finish) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL timeout_%s: finish still %b after %0d cycles", tag, finish, n);
      end
   endtask

   localparam logic [127:0] c_K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] c_K2 = 128'h000102030405060708090a0b0c0d0e0f;

   initial begin
      logic [127:0] vp [4];
      logic [127:0] vc [4];
      logic [127:0] rk, rp;
      int           r0;

      vp[0] = 128'h6bc1bee22e409f96e93d7e117393172a; vc[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
      vp[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51; vc[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
      vp[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef; vc[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
      vp[3] = 128'hf69f2445df4f9b17ad2b417be66c3710; vc[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;

      rst   = 1'b1;
      start = 1'b0;
      key   = '0;
      pt    = '0;
      build_sbox();
      repeat (3) @(negedge clk);
      check1("reset_finish", {127'd0, finish}, 128'd0);
      check1("reset_out", ct, 128'd0);
      rst = 1'b0;

      // First vector, start held two cycles, exactly one finish rise
      r0 = rises;
      start_op(c_K1, vp[0], vc[0], 2);
      wait_finish("v0");
      repeat (20) begin
         @(negedge clk);
         check1("done_hold", {127'd0, finish}, 128'd1);
      end
      check1("single_rise", 128'(rises - r0), 128'd1);

      // Remaining vectors back to back
      for (int i = 1; i < 4; i++) begin
         start_op(c_K1, vp[i], vc[i], 1);
         wait_finish("seq");
      end

      start_op(c_K2, 128'h00112233445566778899aabbccddeeff,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1);
      wait_finish("fips");

      // Start re-pulse with new inputs while busy must be ignored
      start_op(c_K1, vp[1], vc[1], 1);
      repeat (4) @(negedge clk);
      key   = rand128();
      pt    = rand128();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_finish("repulse");

      // Reset in the middle of a run
      start_op(c_K2, vp[2], aes_ref(c_K2, vp[2]), 1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check1("abort_finish", {127'd0, finish}, 128'd0);
      check1("abort_out", ct, 128'd0);
      void'(sbq.pop_back());
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check1("abort_idle", {127'd0, finish}, 128'd0);
      start_op(c_K1, vp[3], vc[3], 1);
      wait_finish("after_abort");

      // Random vectors against the reference model
      for (int i = 0; i < 8; i++) begin
         rk = rand128();
         rp = rand128();
         start_op(rk, rp, aes_ref(rk, rp), 1 + (i % 3));
         wait_finish("rand");
      end

      repeat (3) @(negedge clk);
      check1("scoreboard_empty", 128'(sbq.size()), 128'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
